regfile_dump_480: RTL and testbench
===================================

Name: regfile_dump_480

Overview:
- Consumer end of the write-back path: the 32x32 integer register file that accepts the selected write-back word (WD) from the write-back mux.
- Two combinational read ports feed the decode/ALU stage.
- A sequential dump engine streams all 32 registers over a valid/ready handshake to a debug/trace sink.
- x0 is hardwired to zero.

Parameters:
- NREG, 32, number of architectural registers (power of two; address width = log2(NREG)).
- XLEN, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- RegWrite  in  1  write enable for the write-back port.
- rd  in  5  destination register index.
- WD  in  XLEN  write-back data from the write-back mux.
- rs1  in  5  read port 1 index.
- rs2  in  5  read port 2 index.
- RD1  out  XLEN  read data 1 (combinational).
- RD2  out  XLEN  read data 2 (combinational).
- dump_start  in  1  request a full register dump.
- dump_ready  in  1  sink accepts the current beat.
- dump_valid  out  1  beat valid.
- dump_addr  out  5  register index of the current beat.
- dump_data  out  XLEN  register value of the current beat.
- dump_busy  out  1  dump in progress.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: on rising clk with rst=1:
  - all registers cleared to 0.
  - FSM goes to IDLE.
  - dump_valid=0, dump_addr=0, dump_data=0, dump_busy=0, dump_done=0.
  - A dump in flight is abandoned with no done pulse.
  - A write on the reset edge is discarded.
- Write:
  - On rising clk with RegWrite=1 and rd!=0: regs[rd] <= WD.
  - Writes to x0 are ignored; x0 always reads 0.
- Read:
  - RD1 = regs[rs1], RD2 = regs[rs2], combinational, zero latency.
  - rs=0 returns 0.
- FSM states: IDLE, DUMP, DONE.
- IDLE:
  - dump_start=1 -> DUMP next cycle.
  - dump_addr=0, dump_data=regs[0]=0, dump_valid=1, dump_busy=1.
- DUMP:
  - dump_valid=1. dump_addr and dump_data are held stable while dump_ready=0.
  - A write during a stall does not alter the presented dump_data.
  - On dump_valid && dump_ready with dump_addr<31: dump_addr <= dump_addr+1, and dump_data captures regs[dump_addr+1] write-first. A write to that same register on the same edge is reflected in the captured value.
  - On handshake with dump_addr=31 -> DONE; dump_valid <= 0.
- DONE:
  - dump_done=1 for exactly one cycle, dump_busy=0, then IDLE.
- Other dump rules:
  - dump_start while in DUMP or DONE is ignored, not queued.
  - Exactly 32 beats per dump, addresses 0..31 in order, no wrap past 31.
  - Normal reads and writes continue unaffected during a dump; the dump never stalls the core.

Optional Feature:
- Macro RF_BYPASS_EN: write-to-read forwarding.
- Defined: if RegWrite=1, rd!=0 and rs1==rd (resp. rs2==rd), RD1 (resp. RD2) returns WD in the same cycle, before the edge.
- Undefined: RD1/RD2 return the stored value; the new value is visible from the cycle after the write edge.
- x0 is never forwarded in either case.

Test Plan:
- Reset then read:
  - assert rst 2 cycles, then read rs1=5, rs2=31 -> RD1=0, RD2=0.
  - dump_valid=0, dump_busy=0.
- Write/read and x0:
  - write x3=0xDEADBEEF, then x0=0x12345678.
  - next cycle rs1=3, rs2=0 -> RD1=0xDEADBEEF, RD2=0.
- Bypass:
  - RegWrite=1, rd=7, WD=0xA5A5A5A5, rs1=7 in the same cycle.
  - RD1=0xA5A5A5A5 with RF_BYPASS_EN; old value (0) without it.
- Full dump, dump_ready=1 constantly, after writing x1..x31 = index*0x11:
  - 32 consecutive beats, addr 0..31, data 0, 0x11, ..., 0x20F.
  - dump_done pulses 1 cycle after beat 31, then IDLE.
- Backpressure:
  - dump_ready toggles 1,0,0,1 and x5 is written during a stall while beat 5 is presented.
  - Beat data is unchanged until accepted; no beat is lost or duplicated.
  - A second dump_start mid-dump is ignored.
- Reset mid-dump:
  - rst=1 at beat 10 -> next cycle dump_valid=0, dump_busy=0, no dump_done pulse, all registers read 0.

Source files
------------

// File: rtl/regfile_dump_480.sv
// regfile_dump_480: NREG x XLEN register file with two combinational read ports and a
// valid/ready dump engine that streams every register in order. Define RF_BYPASS_EN for forwarding.
module regfile_dump_480 #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] WD,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            dump_start,
  input  logic            dump_ready,
  output logic            dump_valid,
  output logic [AW-1:0]   dump_addr,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_busy,
  output logic            dump_done
);

  typedef enum logic [1:0] {StIdle, StDump, StDone} state_e;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   addr_nxt;
  logic            wr_en;

  assign wr_en = RegWrite && (rd != '0);

  // regs_d is the write-first view of the array, also used by the dump capture.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rd] = WD;
  end

  always_comb begin
    RD1 = (rs1 == '0) ? '0 : regs_q[rs1];
    RD2 = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef RF_BYPASS_EN
    if (wr_en && (rs1 == rd)) RD1 = WD;
    if (wr_en && (rs2 == rd)) RD2 = WD;
`endif
  end

  assign addr_nxt = addr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StDump;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          addr_d  = '0;
          data_d  = '0;
        end
      end
      StDump: begin
        if (dump_ready) begin
          if (addr_q == AW'(NREG - 1)) begin
            state_d = StDone;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_nxt;
            data_d = regs_d[addr_nxt];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;

endmodule

// File: tb/tb_regfile_dump_480.sv
// tb_regfile_dump_480: vector table for read/write behaviour plus a scoreboarded dump stream
// covering full dumps, backpressure, write-first capture and reset mid-dump.
module tb_regfile_dump_480;

`ifdef RF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk, rst, RegWrite;
  logic [4:0]  rd, rs1, rs2, dump_addr;
  logic [31:0] WD, RD1, RD2, dump_data;
  logic        dump_start, dump_ready, dump_valid, dump_busy, dump_done;

  regfile_dump_480 dut (
    .clk       (clk),
    .rst       (rst),
    .RegWrite  (RegWrite),
    .rd        (rd),
    .WD        (WD),
    .rs1       (rs1),
    .rs2       (rs2),
    .RD1       (RD1),
    .RD2       (RD2),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_busy (dump_busy),
    .dump_done (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          beats_seen = 0;
  int          done_cnt = 0;
  beat_t       sb_q [$];
  logic [31:0] m [32];
  vec_t        vt [9];

  logic        prev_stall = 1'b0;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;

  localparam logic [31:0] New5  = 32'h5555_AAAA;
  localparam logic [31:0] New10 = 32'h1010_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    RegWrite = 1'b1;
    rd       = idx;
    WD       = val;
    step();
    RegWrite = 1'b0;
    if (idx != 5'd0) m[idx] = val;
  endtask

  task automatic push_dump(input int special_idx, input logic [31:0] special_val);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.addr = 5'(i);
      b.data = (i == special_idx) ? special_val : m[i];
      sb_q.push_back(b);
    end
  endtask

  // Stream monitor: scoreboard on each accepted beat, hold check on each stalled beat.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && prev_stall) begin
      chk("stall_hold_addr", 32'(dump_addr), 32'(prev_addr));
      chk("stall_hold_data", dump_data, prev_data);
    end
    if (!rst && dump_valid && dump_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra_beat", 32'(dump_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("sb_beat_addr", 32'(dump_addr), 32'(e.addr));
        chk("sb_beat_data", dump_data, e.data);
        beats_seen++;
      end
    end
    if (dump_done) done_cnt++;
    prev_stall = !rst && dump_valid && !dump_ready;
    prev_addr  = dump_addr;
    prev_data  = dump_data;
  end

  initial begin
    int cyc;
    bit wrote5;

    vt[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd5, 5'd31, 32'h0, 32'h0};
    vt[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0, 5'd0,  32'h0, 32'h0};
    vt[2] = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd0,  32'hDEADBEEF, 32'h0};
    vt[3] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd3,
              Byp ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF};
    vt[4] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vt[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd0,
              Byp ? 32'hCAFEF00D : 32'h0, 32'h0};
    vt[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd3, 32'hCAFEF00D, 32'hDEADBEEF};
    vt[7] = '{1'b1, 5'd3,  32'h01234567, 5'd2, 5'd3,
              32'h0, Byp ? 32'h01234567 : 32'hDEADBEEF};
    vt[8] = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd0,  32'h01234567, 32'h0};

    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    rst = 1'b1; RegWrite = 1'b0; rd = '0; WD = '0; rs1 = '0; rs2 = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("reset_valid", 32'(dump_valid), 32'h0);
    chk("reset_busy",  32'(dump_busy),  32'h0);
    chk("reset_done",  32'(dump_done),  32'h0);
    chk("reset_addr",  32'(dump_addr),  32'h0);
    chk("reset_data",  dump_data,       32'h0);

    for (int i = 0; i < 9; i++) begin
      RegWrite = vt[i].we; rd = vt[i].rd; WD = vt[i].wd; rs1 = vt[i].rs1; rs2 = vt[i].rs2;
      #1;
      chk($sformatf("vec%0d_rd1", i), RD1, vt[i].e1);
      chk($sformatf("vec%0d_rd2", i), RD2, vt[i].e2);
      if (vt[i].we && vt[i].rd != 5'd0) m[vt[i].rd] = vt[i].wd;
      step();
    end
    RegWrite = 1'b0;

    // Full dump with the sink always ready.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 32'h11));
    push_dump(-1, 32'h0);
    beats_seen = 0; done_cnt = 0;
    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    chk("full_first_valid", 32'(dump_valid), 32'h1);
    chk("full_first_busy",  32'(dump_busy),  32'h1);
    chk("full_first_addr",  32'(dump_addr),  32'h0);
    repeat (32) step();
    chk("full_done_pulse",  32'(dump_done),  32'h1);
    chk("full_done_busy",   32'(dump_busy),  32'h0);
    chk("full_done_valid",  32'(dump_valid), 32'h0);
    chk("full_beats",       32'(beats_seen), 32'd32);
    chk("full_sb_empty",    32'(sb_q.size()), 32'h0);
    step();
    chk("full_done_single", 32'(dump_done),  32'h0);
    chk("full_done_count",  32'(done_cnt),   32'h1);

    // Backpressure 1,0,0,1; write x5 while beat 5 stalls; write-first x10 on beat 9 accept.
    push_dump(10, New10);
    beats_seen = 0; done_cnt = 0; wrote5 = 1'b0; cyc = 0;
    dump_ready = 1'b0; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    while (dump_busy && cyc < 200) begin
      dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      RegWrite = 1'b0;
      dump_start = (cyc == 20);
      if (dump_valid && dump_addr == 5'd5 && !dump_ready && !wrote5) begin
        RegWrite = 1'b1; rd = 5'd5; WD = New5; wrote5 = 1'b1;
      end
      if (dump_valid && dump_addr == 5'd9 && dump_ready) begin
        RegWrite = 1'b1; rd = 5'd10; WD = New10;
      end
      step();
      cyc++;
    end
    RegWrite = 1'b0; dump_start = 1'b0;
    m[5] = New5; m[10] = New10;
    chk("bp_finished",   32'(dump_busy), 32'h0);
    chk("bp_done_pulse", 32'(dump_done), 32'h1);
    chk("bp_x5_written", 32'(wrote5),    32'h1);
    repeat (3) step();
    chk("bp_no_restart", 32'(dump_valid), 32'h0);
    chk("bp_idle_busy",  32'(dump_busy),  32'h0);
    chk("bp_beats",      32'(beats_seen), 32'd32);
    chk("bp_sb_empty",   32'(sb_q.size()), 32'h0);
    chk("bp_done_count", 32'(done_cnt),   32'h1);
    rs1 = 5'd5; rs2 = 5'd10;
    #1;
    chk("bp_read_x5",  RD1, New5);
    chk("bp_read_x10", RD2, New10);

    // Reset while beat 10 is presented.
    push_dump(-1, 32'h0);
    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    cyc = 0;
    while (dump_addr != 5'd10 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("rst_reached_beat10", 32'(dump_addr), 32'd10);
    rst = 1'b1; done_cnt = 0;
    step();
    rst = 1'b0;
    sb_q.delete();
    chk("rst_mid_valid", 32'(dump_valid), 32'h0);
    chk("rst_mid_busy",  32'(dump_busy),  32'h0);
    chk("rst_mid_addr",  32'(dump_addr),  32'h0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_clear_x%0d", i), RD1, 32'h0);
    end
    repeat (2) step();
    chk("rst_no_done",   32'(done_cnt),   32'h0);
    chk("rst_stay_idle", 32'(dump_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
